// File: rtl/serial_arbiter.sv
// serial_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one
//   parallel-to-serial converter. A winner's word is latched and issued to
//   the converter with a one-cycle start pulse. The requester then receives
//   either an ack when the converter finishes or a nack when the converter
//   does not finish within TIMEOUT_CYCLES.
//
// Parameters
//   NUM_REQ        number of requesters
//   DATA_BITS      width of each requester word and of the converter port
//   TIMEOUT_CYCLES cycles allowed between the start pulse and finish
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester request, held until ack or nack
//   req_data   requester i word at [i*DATA_BITS +: DATA_BITS]
//   ack        one-cycle pulse: transfer of requester i completed
//   nack       one-cycle pulse: transfer of requester i timed out
//   grant_id   index of the current or most recent grant
//   busy       high whenever the arbiter is not idle
//   p2s_data   word presented to the converter
//   p2s_start  one-cycle converter start pulse
//   p2s_busy   converter busy flag (informational only)
//   p2s_finish converter one-cycle finish pulse

module serial_arbiter #(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_BITS      = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           nack,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic [DATA_BITS-1:0]         p2s_data,
    output logic                         p2s_start,
    input  logic                         p2s_busy,
    input  logic                         p2s_finish
);

    localparam int unsigned NREQ  = NUM_REQ;
    localparam int          CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_ERR
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        last;
    logic [ID_W-1:0]        last_next;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic [NUM_REQ-1:0]     ack_next;
    logic [NUM_REQ-1:0]     nack_next;
    logic [ID_W-1:0]        grant_next;
    logic                   busy_next;
    logic [DATA_BITS-1:0]   data_next;
    logic                   start_next;

    logic                   found;
    logic [ID_W-1:0]        win_id;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [DATA_BITS-1:0]   words [NUM_REQ];

    // Converter busy is status only; it never terminates a wait.
    logic                   unused_p2s_busy;
    assign unused_p2s_busy = p2s_busy;

    for (genvar j = 0; j < NUM_REQ; j++) begin : g_words
        assign words[j] = req_data[j*DATA_BITS +: DATA_BITS];
    end

    // Round-robin search: first asserted request after 'last', wrapping,
    // with 'last' itself checked at the end of the sweep.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx  = (32'(last) + i) % NREQ;
            cand = ID_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end

    always_comb begin
        grant_onehot           = '0;
        grant_onehot[grant_id] = 1'b1;
    end

    always_comb begin
        state_next = state;
        ack_next   = '0;
        nack_next  = '0;
        start_next = 1'b0;
        data_next  = p2s_data;
        grant_next = grant_id;
        last_next  = last;
        count_next = count;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_next = S_ISSUE;
                    grant_next = win_id;
                    data_next  = words[win_id];
                    start_next = 1'b1;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
                count_next = '0;
            end
            S_WAIT: begin
                // Finish takes priority over a timeout in the same cycle.
                if (p2s_finish) begin
                    state_next = S_ACK;
                    ack_next   = grant_onehot;
                end else if (count == CNT_LAST) begin
                    state_next = S_ERR;
                    nack_next  = grant_onehot;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            S_ACK, S_ERR: begin
                last_next  = grant_id;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last      <= ID_W'(NUM_REQ - 1);
            count     <= '0;
            ack       <= '0;
            nack      <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            p2s_data  <= '0;
            p2s_start <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            count     <= count_next;
            ack       <= ack_next;
            nack      <= nack_next;
            grant_id  <= grant_next;
            busy      <= busy_next;
            p2s_data  <= data_next;
            p2s_start <= start_next;
        end
    end

    a_ack_nack_excl: assert property (@(posedge clk) disable iff (rst)
        !((|ack) && (|nack)));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(ack));
    a_nack_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(nack));

endmodule
